// File: rtl/cache_pkg.sv
// Shared types and sizing helpers for the set-associative L1 cache.
// State encoding plus index/tag width helpers derived from WIDTH and SETS.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WTHRU
    } state_t;

    function automatic int index_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int width, input int sets);
        return width - 2 - $clog2(sets);
    endfunction

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_SETS   = 8;
    localparam int INDEX_BITS = index_bits(DEF_SETS);
    localparam int TAG_BITS   = tag_bits(DEF_WIDTH, DEF_SETS);

endpackage

// File: rtl/cache_set_array.sv
// One way of the cache: valid bits, tags and one data word per set.
// Ports: rd_index -> rd_valid/rd_tag/rd_data (combinational read);
//        wr_en/wr_index/wr_tag/wr_data (registered write, sets valid).
//        rst clears valid bits only.
module cache_set_array #(
    parameter int WIDTH = 32,
    parameter int SETS  = 8,
    parameter int TW    = 27
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(SETS)-1:0]  rd_index,
    output logic                     rd_valid,
    output logic [TW-1:0]            rd_tag,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(SETS)-1:0]  wr_index,
    input  logic [TW-1:0]            wr_tag,
    input  logic [WIDTH-1:0]         wr_data
);

    logic [SETS-1:0]  valid;
    logic [TW-1:0]    tags [SETS];
    logic [WIDTH-1:0] data [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];

endmodule

// File: rtl/assoc_cache.sv
// Blocking write-through, no-write-allocate L1 cache (1 or 2 ways, LRU).
// Ports: cpu_* pipeline side with stall, mem_* backing side with mem_ack,
//        hit_count/miss_count statistics (built only with ASSOC_CACHE_STATS_EN).
module assoc_cache
    import cache_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SETS  = 8,
    parameter int WAYS  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
);

    localparam int IW = index_bits(SETS);
    localparam int TW = tag_bits(WIDTH, SETS);

    state_t state, state_nx;

    logic [IW-1:0]    idx;
    logic [TW-1:0]    tag;
    logic [WAYS-1:0]  way_valid, way_hit, way_we;
    logic [TW-1:0]    way_tag  [WAYS];
    logic [WIDTH-1:0] way_data [WAYS];
    logic [WIDTH-1:0] wr_data, hit_data;
    logic             hit, hit_way, victim;
    logic             ack, ld_hit, lru_upd, upd_way;
    logic             unused_lsb;

    assign idx        = cpu_addr[IW+1:2];
    assign tag        = cpu_addr[WIDTH-1:IW+2];
    assign unused_lsb = ^cpu_addr[1:0];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_set_array #(
            .WIDTH (WIDTH),
            .SETS  (SETS),
            .TW    (TW)
        ) u_set (
            .clk      (clk),
            .rst      (rst),
            .rd_index (idx),
            .rd_valid (way_valid[w]),
            .rd_tag   (way_tag[w]),
            .rd_data  (way_data[w]),
            .wr_en    (way_we[w]),
            .wr_index (idx),
            .wr_tag   (tag),
            .wr_data  (wr_data)
        );
        assign way_hit[w] = way_valid[w] && (way_tag[w] == tag);
        // Fill writes the victim; a write-through only refreshes a hit way.
        assign way_we[w]  = ack && ((state == FILL) ? (victim == 1'(w))
                                  : ((state == WTHRU) && way_hit[w]));
    end

    assign hit      = |way_hit;
    assign hit_data = way_hit[0] ? way_data[0] : way_data[WAYS-1];
    assign wr_data  = (state == FILL) ? mem_rdata : cpu_wdata;

    // mem_req is already low in reset and IDLE, so stray acks drop out here.
    assign ack     = mem_ack && mem_req;
    assign ld_hit  = !rst && (state == IDLE) && cpu_req && !cpu_we && hit;
    assign lru_upd = ld_hit || (ack && ((state == FILL)
                                     || ((state == WTHRU) && hit)));
    assign upd_way = (state == FILL) ? victim : hit_way;

    if (WAYS == 2) begin : g_lru
        // One bit per set naming the way to evict next.
        logic [SETS-1:0] lru;
        always_ff @(posedge clk) begin
            if (rst) begin
                lru <= '0;
            end else if (lru_upd) begin
                lru[idx] <= ~upd_way;
            end
        end
        assign hit_way = way_hit[1];
        assign victim  = !way_valid[0] ? 1'b0
                       : !way_valid[1] ? 1'b1
                       : lru[idx];
    end else begin : g_dm
        logic unused_upd;
        assign unused_upd = lru_upd ^ upd_way;
        assign hit_way    = 1'b0;
        assign victim     = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (cpu_req && cpu_we) begin
                    state_nx = WTHRU;
                end else if (cpu_req && !hit) begin
                    state_nx = FILL;
                end
            end
            FILL, WTHRU: begin
                if (ack) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        stall     = 1'b0;
        cpu_rdata = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    stall = cpu_req && (cpu_we || !hit);
                    if (ld_hit) begin
                        cpu_rdata = hit_data;
                    end
                end
                FILL: begin
                    mem_req = 1'b1;
                    stall   = 1'b1;
                end
                WTHRU: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    // Store retires in the ack cycle itself.
                    stall   = !mem_ack;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = {cpu_addr[WIDTH-1:2], 2'b00};
    assign mem_wdata = cpu_wdata;

`ifdef ASSOC_CACHE_STATS_EN
    logic        acc_miss;
    logic [31:0] hit_q, miss_q;

    assign acc_miss = (state == IDLE) && cpu_req && (cpu_we || !hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (ld_hit) begin
                hit_q <= hit_q + 32'd1;
            end
            if (acc_miss) begin
                miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
